strokie_alu_seq: RTL and testbench

STROKIE_ALU_SEQ -- requirements
Module: strokie_alu_seq

---
 rtl/strokie_alu_seq.sv | 245 ++++++++++++++++++++++++
 tb/tb_strokie_alu_seq.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/strokie_alu_seq.sv
// Sequenced fp ALU: one fp32 and two fp16 cores behind a single-issue FSM,
// with results (and timeout/illegal-mode errors) queued in a result FIFO.

module strokie_fp_core #(
    parameter int EW = 8,
    parameter int MW = 23
) (
    input  logic [EW+MW:0] i_a,
    input  logic [EW+MW:0] i_b,
    input  logic [1:0]     i_op,
    output logic [EW+MW:0] o_y
);
    localparam int W    = EW + MW + 1;
    localparam int MP   = MW + 1;
    localparam int BIAS = (1 << (EW - 1)) - 1;
    localparam int EMAX = (1 << EW) - 1;

    logic          w_sa, w_sb, w_sbe, w_bsel, w_sbig, w_rs, w_rzero, w_rinf;
    logic [EW-1:0] w_ea, w_eb, w_ebig, w_esml;
    logic [MW:0]   w_ma, w_mb, w_mbig, w_msml, w_den;
    logic [MP+2:0] w_mal;
    logic [MP+3:0] w_sum, w_nrm;
    logic [2*MP-1:0] w_prod, w_quo;
    logic [MW-1:0] w_rfrac;
    int            w_xa, w_xb, w_xbig, w_rexp, w_p;
    logic          w_unused;

    // Denormals flush to zero, results truncate; NaN is not produced.
    always_comb begin
        w_sa    = i_a[W-1];
        w_sb    = i_b[W-1];
        w_sbe   = w_sb ^ (i_op == 2'b01);
        w_ea    = i_a[W-2:MW];
        w_eb    = i_b[W-2:MW];
        w_xa    = {{(32-EW){1'b0}}, w_ea};
        w_xb    = {{(32-EW){1'b0}}, w_eb};
        w_ma    = (w_ea == '0) ? '0 : {1'b1, i_a[MW-1:0]};
        w_mb    = (w_eb == '0) ? '0 : {1'b1, i_b[MW-1:0]};
        w_bsel  = (i_a[W-2:0] < i_b[W-2:0]);
        w_ebig  = w_bsel ? w_eb : w_ea;
        w_esml  = w_bsel ? w_ea : w_eb;
        w_mbig  = w_bsel ? w_mb : w_ma;
        w_msml  = w_bsel ? w_ma : w_mb;
        w_sbig  = w_bsel ? w_sbe : w_sa;
        w_xbig  = {{(32-EW){1'b0}}, w_ebig};
        w_mal   = {w_msml, 3'b000} >> (w_ebig - w_esml);
        w_den   = (w_mb == '0) ? {{MW{1'b0}}, 1'b1} : w_mb;
        w_sum   = '0;
        w_nrm   = '0;
        w_prod  = '0;
        w_quo   = '0;
        w_p     = 0;
        w_rs    = 1'b0;
        w_rzero = 1'b0;
        w_rinf  = 1'b0;
        w_rexp  = 0;
        w_rfrac = '0;
        case (i_op)
            2'b00, 2'b01: begin
                w_rs = w_sbig;
                if (w_sa == w_sbe) w_sum = {1'b0, w_mbig, 3'b000} + {1'b0, w_mal};
                else               w_sum = {1'b0, w_mbig, 3'b000} - {1'b0, w_mal};
                for (int i = 0; i < MP + 4; i++) if (w_sum[i]) w_p = i;
                // Leading one lands on bit MP+3; a carry out gives p=MP+3.
                w_nrm   = w_sum << (MP + 3 - w_p);
                w_rfrac = w_nrm[MP+2 -: MW];
                w_rexp  = w_xbig + w_p - (MP + 2);
                w_rzero = (w_sum == '0);
            end
            2'b10: begin
                w_rs    = w_sa ^ w_sb;
                w_rzero = (w_ma == '0) || (w_mb == '0);
                w_prod  = {{MP{1'b0}}, w_ma} * {{MP{1'b0}}, w_mb};
                if (w_prod[2*MP-1]) begin
                    w_rfrac = w_prod[2*MP-2 -: MW];
                    w_rexp  = w_xa + w_xb - BIAS + 1;
                end else begin
                    w_rfrac = w_prod[2*MP-3 -: MW];
                    w_rexp  = w_xa + w_xb - BIAS;
                end
            end
            default: begin
                w_rs    = w_sa ^ w_sb;
                w_rzero = (w_ma == '0);
                w_rinf  = (w_mb == '0) && (w_ma != '0);
                w_quo   = {w_ma, {MP{1'b0}}} / {{MP{1'b0}}, w_den};
                if (w_quo[MP]) begin
                    w_rfrac = w_quo[MP-1 -: MW];
                    w_rexp  = w_xa - w_xb + BIAS;
                end else begin
                    w_rfrac = w_quo[MP-2 -: MW];
                    w_rexp  = w_xa - w_xb + BIAS - 1;
                end
            end
        endcase
        if (w_rzero || (!w_rinf && w_rexp <= 0)) o_y = {w_rs, {(W-1){1'b0}}};
        else if (w_rinf || w_rexp >= EMAX)       o_y = {w_rs, {EW{1'b1}}, {MW{1'b0}}};
        else                                     o_y = {w_rs, w_rexp[EW-1:0], w_rfrac};
    end

    assign w_unused = ^{w_prod[MW-1:0], w_quo[2*MP-1:MP+1], w_nrm[MP+3], w_nrm[3:0]};
endmodule

module fp32_strokie (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [1:0]  i_op,
    output logic [31:0] o_q,
    output logic        o_ready
);
    strokie_fp_core #(.EW(8), .MW(23)) u_core (.i_a(i_a), .i_b(i_b), .i_op(i_op), .o_y(o_q));
    assign o_ready = 1'b1;
endmodule

module fp16_strokie (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    input  logic [1:0]  i_op,
    output logic [15:0] o_q,
    output logic        o_ready
);
    strokie_fp_core #(.EW(5), .MW(10)) u_core (.i_a(i_a), .i_b(i_b), .i_op(i_op), .o_y(o_q));
    assign o_ready = 1'b1;
endmodule

module strokie_alu_seq #(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [1:0]  op,
    input  logic [1:0]  mode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] Q,
    output logic        out_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int WW = $clog2(MAX_WAIT);

    typedef enum logic {IDLE, EXEC} state_t;

    state_t        r_state, w_state_nxt;
    logic [31:0]   r_a, r_b;
    logic [1:0]    r_op, r_mode;
    logic [WW-1:0] r_wait_cnt;
    logic [32:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [AW:0]   r_count;

    logic [31:0] w_f32_q, w_res;
    logic [15:0] w_f16_hi_q, w_f16_lo_q;
    logic        w_f32_rdy, w_f16_hi_rdy, w_f16_lo_rdy;
    logic        w_accept, w_pop, w_push, w_done;
    logic [32:0] w_push_data;

    fp32_strokie u_f32 (.i_a(r_a), .i_b(r_b), .i_op(r_op), .o_q(w_f32_q), .o_ready(w_f32_rdy));
    fp16_strokie u_f16_hi (.i_a(r_a[31:16]), .i_b(r_b[31:16]), .i_op(r_op),
                           .o_q(w_f16_hi_q), .o_ready(w_f16_hi_rdy));
    fp16_strokie u_f16_lo (.i_a(r_a[15:0]), .i_b(r_b[15:0]), .i_op(r_op),
                           .o_q(w_f16_lo_q), .o_ready(w_f16_lo_rdy));

    assign in_ready  = (r_state == IDLE) && (r_count < (AW+1)'(DEPTH));
    assign out_valid = (r_count != '0);
    assign w_accept  = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign Q         = out_valid ? r_mem[r_rptr][31:0] : '0;
    assign out_err   = out_valid ? r_mem[r_rptr][32] : 1'b0;

    always_comb begin
        w_done = 1'b0;
        w_res  = '0;
        case (r_mode)
            2'b01: begin w_done = w_f32_rdy;                   w_res = w_f32_q; end
            2'b00: begin w_done = w_f16_hi_rdy;                w_res = {w_f16_hi_q, 16'h0000}; end
            2'b10: begin w_done = w_f16_hi_rdy && w_f16_lo_rdy; w_res = {w_f16_hi_q, w_f16_lo_q}; end
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_push_data = '0;
        case (r_state)
            IDLE: if (w_accept) w_state_nxt = EXEC;
            EXEC: begin
                if (r_mode == 2'b11) begin
                    w_push      = 1'b1;
                    w_push_data = {1'b1, 32'h0};
                end else if (w_done) begin
                    w_push      = 1'b1;
                    w_push_data = {1'b0, w_res};
                end else if (r_wait_cnt == WW'(MAX_WAIT - 1)) begin
                    w_push      = 1'b1;
                    w_push_data = {1'b1, 32'h0};
                end
                if (w_push) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= '0;
            r_mode     <= '0;
            r_wait_cnt <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_a        <= A;
                r_b        <= B;
                r_op       <= op;
                r_mode     <= mode;
                r_wait_cnt <= '0;
            end else if (r_state == EXEC && !w_push) begin
                r_wait_cnt <= r_wait_cnt + WW'(1);
            end
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    // Storage needs no reset: the head is masked whenever the count is zero.
    always_ff @(posedge clk) begin
        if (w_push && !rst) r_mem[r_wptr] <= w_push_data;
    end
endmodule

// File: tb/tb_strokie_alu_seq.sv
// Directed bench for strokie_alu_seq: fp results, errors, FIFO full/drain and reset.

module tb_strokie_alu_seq;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready, out_err;
    logic [31:0] A, B, Q;
    logic [1:0]  op, mode;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    strokie_alu_seq #(.DEPTH(4), .MAX_WAIT(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .op(op), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready), .Q(Q), .out_err(out_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for in_ready, then holds in_valid for exactly one edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] o, input logic [1:0] m);
        int n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            total++; bad++;
            $display("FAIL send_wait in_ready got=%b want=1", in_ready);
        end
        A = a; B = b; op = o; mode = m;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; op = '0; mode = '0;
        tick();
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (Q !== 32'h0)        begin bad++; $display("FAIL reset_q got=%h want=00000000", Q); end
        total++; if (out_err !== 1'b0)   begin bad++; $display("FAIL reset_err got=%b want=0", out_err); end
        rst = 1'b0;
    endtask

    task automatic test_fp32_add();
        out_ready = 1'b1;
        send(32'h3F800000, 32'h40000000, 2'b00, 2'b01);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL f32add_early_valid got=%b want=0", out_valid); end
        total++; if (in_ready !== 1'b0)  begin bad++; $display("FAIL f32add_busy_ready got=%b want=0", in_ready); end
        tick();
        total++; if (out_valid !== 1'b1)   begin bad++; $display("FAIL f32add_valid got=%b want=1", out_valid); end
        total++; if (Q !== 32'h40400000)   begin bad++; $display("FAIL f32add_q got=%h want=40400000", Q); end
        total++; if (out_err !== 1'b0)     begin bad++; $display("FAIL f32add_err got=%b want=0", out_err); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL f32add_popped got=%b want=0", out_valid); end
    endtask

    task automatic test_fp32_sub_div();
        out_ready = 1'b1;
        send(32'h40A00000, 32'h40000000, 2'b01, 2'b01);
        tick();
        total++; if (Q !== 32'h40400000) begin bad++; $display("FAIL f32sub_q got=%h want=40400000", Q); end
        tick();
        send(32'h40C00000, 32'h40000000, 2'b11, 2'b01);
        tick();
        total++; if (Q !== 32'h40400000) begin bad++; $display("FAIL f32div_q got=%h want=40400000", Q); end
        tick();
    endtask

    task automatic test_fp16_mul();
        out_ready = 1'b1;
        send(32'h40000000, 32'h42000000, 2'b10, 2'b00);
        tick();
        total++; if (Q !== 32'h46000000) begin bad++; $display("FAIL f16mul_q got=%h want=46000000", Q); end
        total++; if (out_err !== 1'b0)   begin bad++; $display("FAIL f16mul_err got=%b want=0", out_err); end
        tick();
    endtask

    task automatic test_simd_add();
        out_ready = 1'b1;
        send(32'h3C004000, 32'h40004200, 2'b00, 2'b10);
        tick();
        total++; if (Q !== 32'h42004500) begin bad++; $display("FAIL simd_q got=%h want=42004500", Q); end
        total++; if (out_err !== 1'b0)   begin bad++; $display("FAIL simd_err got=%b want=0", out_err); end
        tick();
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        send(32'h12345678, 32'h9ABCDEF0, 2'b00, 2'b11);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL illegal_early got=%b want=0", out_valid); end
        tick();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL illegal_valid got=%b want=1", out_valid); end
        total++; if (out_err !== 1'b1)   begin bad++; $display("FAIL illegal_err got=%b want=1", out_err); end
        total++; if (Q !== 32'h0)        begin bad++; $display("FAIL illegal_q got=%h want=00000000", Q); end
        tick();
    endtask

    task automatic test_timeout();
        out_ready = 1'b1;
        force dut.w_f32_rdy = 1'b0;
        send(32'h3F800000, 32'h40000000, 2'b00, 2'b01);
        repeat (15) tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL timeout_early got=%b want=0", out_valid); end
        total++; if (in_ready !== 1'b0)  begin bad++; $display("FAIL timeout_busy got=%b want=0", in_ready); end
        tick();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL timeout_valid got=%b want=1", out_valid); end
        total++; if (out_err !== 1'b1)   begin bad++; $display("FAIL timeout_err got=%b want=1", out_err); end
        total++; if (Q !== 32'h0)        begin bad++; $display("FAIL timeout_q got=%h want=00000000", Q); end
        release dut.w_f32_rdy;
        tick();
    endtask

    task automatic test_full();
        out_ready = 1'b0;
        send(32'h3F800000, 32'h3F800000, 2'b00, 2'b01);
        send(32'h3F800000, 32'h40000000, 2'b00, 2'b01);
        send(32'h40000000, 32'h40000000, 2'b00, 2'b01);
        send(32'h40000000, 32'h40400000, 2'b10, 2'b01);
        tick();
        total++; if (in_ready !== 1'b0)  begin bad++; $display("FAIL full_in_ready got=%b want=0", in_ready); end
        total++; if (Q !== 32'h40000000) begin bad++; $display("FAIL full_head got=%h want=40000000", Q); end
        tick();
        tick();
        total++; if (Q !== 32'h40000000) begin bad++; $display("FAIL full_hold got=%h want=40000000", Q); end
        total++; if (in_ready !== 1'b0)  begin bad++; $display("FAIL full_still_blocked got=%b want=0", in_ready); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL full_pop_ready got=%b want=1", in_ready); end
        total++; if (Q !== 32'h40400000) begin bad++; $display("FAIL full_second got=%h want=40400000", Q); end
        out_ready = 1'b1;
        tick();
        total++; if (Q !== 32'h40800000) begin bad++; $display("FAIL full_third got=%h want=40800000", Q); end
        tick();
        total++; if (Q !== 32'h40C00000) begin bad++; $display("FAIL full_fourth got=%h want=40C00000", Q); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL full_drained got=%b want=0", out_valid); end
    endtask

    task automatic test_reset_exec();
        out_ready = 1'b0;
        send(32'h3F800000, 32'h3F800000, 2'b00, 2'b01);
        send(32'h40000000, 32'h40000000, 2'b00, 2'b01);
        tick();
        force dut.w_f32_rdy = 1'b0;
        send(32'h3F800000, 32'h40000000, 2'b00, 2'b01);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rstx_queued got=%b want=1", out_valid); end
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstx_valid got=%b want=0", out_valid); end
        total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL rstx_in_ready got=%b want=1", in_ready); end
        repeat (20) tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstx_no_push got=%b want=0", out_valid); end
        release dut.w_f32_rdy;
        tick();
    endtask

    initial begin
        test_reset();
        test_fp32_add();
        test_fp32_sub_div();
        test_fp16_mul();
        test_simd_add();
        test_illegal();
        test_timeout();
        test_full();
        test_reset_exec();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
